// File: rtl/iir_biquad_sequencer_if.sv
// Sample-in, sample-out and shared-multiplier signals of the biquad sequencer.
// slave is the sequencer's view; master is the surrounding datapath/bench view.
interface iir_biquad_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_x;
  logic [23:0] coef_b0;
  logic [23:0] coef_b1;
  logic [23:0] coef_b2;
  logic [23:0] coef_a1;
  logic [23:0] coef_a2;
  logic        clr;
  logic        mul_valid_in;
  logic [23:0] mul_a;
  logic [23:0] mul_b;
  logic        mul_valid_out;
  logic [23:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_y;
  logic        err;

  modport slave (
    input  in_valid, in_x, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2, clr,
    input  mul_valid_out, mul_p, out_ready,
    output in_ready, mul_valid_in, mul_a, mul_b, out_valid, out_y, err
  );

  modport master (
    output in_valid, in_x, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2, clr,
    output mul_valid_out, mul_p, out_ready,
    input  in_ready, mul_valid_in, mul_a, mul_b, out_valid, out_y, err
  );
endinterface

// File: rtl/iir_biquad_sequencer.sv
// DF-I biquad sequencer: issues 5 Q2.22 products per sample, out_valid 6+MUL_LAT cycles after accept.
// out_y holds while out_ready is low; no new sample is accepted until the output handshake.
module iir_biquad_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  iir_biquad_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  typedef struct packed {
    logic [23:0] b0;
    logic [23:0] b1;
    logic [23:0] b2;
    logic [23:0] a1;
    logic [23:0] a2;
  } coef_t;

  localparam logic signed [26:0] SAT_MAX = 27'sd8388607;
  localparam logic signed [26:0] SAT_MIN = -27'sd8388608;

  state_t             state_q, state_d;
  coef_t              coef_q;
  logic [23:0]        x0_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [26:0] acc_q, acc_d, p_ext;
  logic [2:0]         issue_cnt_q, issue_nxt;
  logic [2:0]         ret_cnt_q;
  logic [2:0]         pend_q;
  logic               clr_pend_q;
  logic               accept, ret_ok, last_ret, stray, out_hs, clr_now;
  logic [23:0]        op_a, op_b, y_sat;

  function automatic logic [23:0] sat24(input logic signed [26:0] v);
    if (v > SAT_MAX)      return 24'h7FFFFF;
    else if (v < SAT_MIN) return 24'h800000;
    else                  return v[23:0];
  endfunction

  assign accept   = (state_q == IDLE) && bus.in_valid && bus.in_ready;
  // Results are trusted only while something is in flight; anything else is a stray.
  assign ret_ok   = bus.mul_valid_out && (pend_q != 3'd0);
  assign stray    = bus.mul_valid_out && (pend_q == 3'd0);
  assign last_ret = ret_ok && (ret_cnt_q == 3'd4);
  assign out_hs   = (state_q == OUT) && bus.out_valid && bus.out_ready;
  assign clr_now  = (state_q == IDLE) && (bus.clr || clr_pend_q);
  assign p_ext    = {{3{bus.mul_p[23]}}, bus.mul_p};
  assign y_sat    = sat24(acc_d);

  always_comb begin
    acc_d = acc_q;
    if (ret_ok) begin
      if (ret_cnt_q < 3'd3) acc_d = acc_q + p_ext;
      else                  acc_d = acc_q - p_ext;
    end
  end

  always_comb begin
    issue_nxt = issue_cnt_q + 3'd1;
    case (issue_nxt)
      3'd1:    begin op_a = coef_q.b1; op_b = x1_q; end
      3'd2:    begin op_a = coef_q.b2; op_b = x2_q; end
      3'd3:    begin op_a = coef_q.a1; op_b = y1_q; end
      3'd4:    begin op_a = coef_q.a2; op_b = y2_q; end
      default: begin op_a = coef_q.b0; op_b = x0_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (issue_cnt_q == 3'd4) state_d = WAIT;
      WAIT:    if (last_ret) state_d = OUT;
      OUT:     if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      coef_q           <= '0;
      x0_q             <= '0;
      x1_q             <= '0;
      x2_q             <= '0;
      y1_q             <= '0;
      y2_q             <= '0;
      acc_q            <= '0;
      issue_cnt_q      <= '0;
      ret_cnt_q        <= '0;
      pend_q           <= '0;
      clr_pend_q       <= 1'b0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.out_y        <= '0;
      bus.mul_valid_in <= 1'b0;
      bus.mul_a        <= '0;
      bus.mul_b        <= '0;
      bus.err          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.in_ready  <= (state_d == IDLE);
      bus.out_valid <= (state_d == OUT);
      bus.err       <= bus.err | stray;
      pend_q        <= pend_q + {2'b00, bus.mul_valid_in} - {2'b00, ret_ok};

      if (accept) begin
        acc_q     <= '0;
        ret_cnt_q <= '0;
      end else begin
        acc_q <= acc_d;
        if (ret_ok) ret_cnt_q <= (ret_cnt_q == 3'd4) ? 3'd0 : ret_cnt_q + 3'd1;
      end

      // A clear that arrives while busy waits for IDLE so in-flight work is untouched.
      if (clr_now) begin
        x1_q       <= '0;
        x2_q       <= '0;
        y1_q       <= '0;
        y2_q       <= '0;
        clr_pend_q <= 1'b0;
      end else if (bus.clr && state_q != IDLE) begin
        clr_pend_q <= 1'b1;
      end

      if (accept) begin
        coef_q           <= '{b0: bus.coef_b0, b1: bus.coef_b1, b2: bus.coef_b2,
                              a1: bus.coef_a1, a2: bus.coef_a2};
        x0_q             <= bus.in_x;
        issue_cnt_q      <= '0;
        bus.mul_valid_in <= 1'b1;
        bus.mul_a        <= bus.coef_b0;
        bus.mul_b        <= bus.in_x;
      end else if (state_q == ISSUE) begin
        if (issue_cnt_q == 3'd4) begin
          bus.mul_valid_in <= 1'b0;
          bus.mul_a        <= '0;
          bus.mul_b        <= '0;
        end else begin
          issue_cnt_q <= issue_nxt;
          bus.mul_a   <= op_a;
          bus.mul_b   <= op_b;
        end
      end

      // Output and history take the final sum on the same edge the 5th product lands.
      if (state_q == WAIT && last_ret) begin
        bus.out_y <= y_sat;
        x2_q      <= x1_q;
        x1_q      <= x0_q;
        y2_q      <= y1_q;
        y1_q      <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Bench for iir_biquad_sequencer: saturating Q2.22 multiplier model plus an output scoreboard.
module tb_iir_biquad_sequencer;
  localparam int MUL_LAT = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  iir_biquad_sequencer_if bus ();

  iir_biquad_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [23:0] exp_q[$];
  logic [47:0] op_q[$];

  logic              inject = 1'b0;
  logic [23:0]       inject_p = '0;
  logic [MUL_LAT-1:0] pv;
  logic [23:0]       pp[MUL_LAT];

  function automatic logic [23:0] qmul(input logic [23:0] a, input logic [23:0] b);
    logic signed [47:0] full;
    full = $signed(a) * $signed(b);
    full = full >>> 22;
    if (full > 48'sd8388607) return 24'h7FFFFF;
    if (full < -48'sd8388608) return 24'h800000;
    return full[23:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < MUL_LAT; i++) pp[i] <= '0;
    end else begin
      pv    <= {pv[MUL_LAT-2:0], bus.mul_valid_in};
      pp[0] <= qmul(bus.mul_a, bus.mul_b);
      for (int i = 1; i < MUL_LAT; i++) pp[i] <= pp[i-1];
    end
  end

  assign bus.mul_valid_out = pv[MUL_LAT-1] | inject;
  assign bus.mul_p         = inject ? inject_p : pp[MUL_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard on output handshakes, plus latency, pulse count and operand order.
  initial begin
    int acc_cyc = 0;
    int n_issue = 0;
    logic ov_prev = 1'b0;
    logic [47:0] pair;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.in_valid && bus.in_ready) begin
          acc_cyc = cyc;
          n_issue = 0;
        end
        if (bus.mul_valid_in) begin
          n_issue++;
          if (op_q.size() > 0) begin
            pair = op_q.pop_front();
            check("mul_a_order", bus.mul_a, pair[47:24]);
            check("mul_b_order", bus.mul_b, pair[23:0]);
          end
        end else begin
          check("mul_a_idle", bus.mul_a, 0);
          check("mul_b_idle", bus.mul_b, 0);
        end
        if (bus.out_valid && !ov_prev) begin
          check("latency", cyc - acc_cyc, MUL_LAT + 6);
          check("issue_pulses", n_issue, 5);
        end
        ov_prev = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got %h, none expected", bus.out_y);
          end else begin
            check("out_y", bus.out_y, exp_q.pop_front());
          end
        end
      end else begin
        ov_prev = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_coef(input logic [23:0] b0, b1, b2, a1, a2);
    bus.coef_b0 = b0;
    bus.coef_b1 = b1;
    bus.coef_b2 = b2;
    bus.coef_a1 = a1;
    bus.coef_a2 = a2;
  endtask

  task automatic wait_out();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) got = 1;
    end
    if (!got) check("out_handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] x, input logic c, input logic [23:0] y_exp,
                      input bit do_push, input bit do_wait);
    bit got = 0;
    bus.in_x     = x;
    bus.clr      = c;
    bus.in_valid = 1'b1;
    if (do_push) exp_q.push_back(y_exp);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
    if (do_wait) wait_out();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_y"}, bus.out_y, 0);
    check({tag, "_mul_valid_in"}, bus.mul_valid_in, 0);
    check({tag, "_mul_a"}, bus.mul_a, 0);
    check({tag, "_mul_b"}, bus.mul_b, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    bit got;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    set_coef(24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pass-through with operand order
    set_coef(24'h200000, 24'h0, 24'h0, 24'h0, 24'h0);
    op_q.push_back({24'h200000, 24'h100000});
    repeat (4) op_q.push_back(48'h0);
    send(24'h100000, 1'b0, 24'h080000, 1, 1);

    // Feedback: y = x - 0.5*y1; third sample also checks history in operands
    set_coef(24'h400000, 24'h0, 24'h0, 24'h200000, 24'h0);
    send(24'h100000, 1'b1, 24'h100000, 1, 1);
    send(24'h000000, 1'b0, 24'hF80000, 1, 1);
    op_q.push_back({24'h400000, 24'h000000});
    op_q.push_back({24'h000000, 24'h000000});
    op_q.push_back({24'h000000, 24'h100000});
    op_q.push_back({24'h200000, 24'hF80000});
    op_q.push_back({24'h000000, 24'h100000});
    send(24'h000000, 1'b0, 24'h040000, 1, 1);

    // Saturation, both polarities
    set_coef(24'h600000, 24'h600000, 24'h600000, 24'h0, 24'h0);
    send(24'h600000, 1'b1, 24'h7FFFFF, 1, 1);
    send(24'h600000, 1'b0, 24'h7FFFFF, 1, 1);
    send(24'h600000, 1'b0, 24'h7FFFFF, 1, 1);
    send(24'hA00000, 1'b1, 24'h800000, 1, 1);
    send(24'hA00000, 1'b0, 24'h800000, 1, 1);
    send(24'hA00000, 1'b0, 24'h800000, 1, 1);

    // Backpressure: output held, no accept, no issue
    set_coef(24'h400000, 24'h0, 24'h0, 24'h0, 24'h0);
    bus.out_ready = 1'b0;
    send(24'h123456, 1'b1, 24'h123456, 1, 0);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1;
    end
    if (!got) check("stall_out_valid_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_x     = 24'h777777;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_y", bus.out_y, 24'h123456);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_mul_valid_in", bus.mul_valid_in, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_out();

    // Pending clr raised during WAIT
    set_coef(24'h400000, 24'h400000, 24'h0, 24'h0, 24'h0);
    send(24'h100000, 1'b1, 24'h100000, 1, 1);
    send(24'h080000, 1'b0, 24'h180000, 1, 0);
    repeat (8) @(posedge clk);
    #1;
    bus.clr = 1'b1;
    check("clr_in_wait_busy", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    wait_out();
    send(24'h040000, 1'b0, 24'h040000, 1, 1);

    // Stray result in IDLE sets sticky err and is otherwise ignored
    set_coef(24'h400000, 24'h0, 24'h0, 24'h0, 24'h0);
    inject_p = 24'h000123;
    inject   = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    @(negedge clk);
    check("err_set", bus.err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", bus.err, 1);
    @(posedge clk);
    #1;
    send(24'h000111, 1'b1, 24'h000111, 1, 1);
    check("err_sticky_after_sample", bus.err, 1);

    // Asynchronous reset during ISSUE
    send(24'h222222, 1'b0, 24'h0, 0, 0);
    check("issue_active", bus.mul_valid_in, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(24'h0ABCDE, 1'b0, 24'h0ABCDE, 1, 1);
    repeat (5) @(posedge clk);
    #1;
    check("err_after_reset", bus.err, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
